qspi_psram_sampled: RTL and testbench
=====================================

// Module: qspi_psram_sampled
// PURPOSE
//  Parametrised QSPI PSRAM model, clocked by system clk, for ExoTiny sim wrappers.
//  Oversamples SCK/CS, decodes SPI and QPI command frames, serves byte memory.
//  Adds QPI mode, configurable dummy cycles, abort on CS and split sd_o/sd_oen.
//  The wrapper resolves the tristate bus.
// PARAMETERS
//  DEPTH      16777216  memory size in bytes; addresses wrap modulo DEPTH
//  DUMMY      6         SCK cycles between address and data for 0xEB
//  SYNC       2         synchroniser flops on sck_i/cs_in/sd_i (0 = none)
//  INIT_FILE  ""        $readmemh image loaded at time 0 if non-empty
// PORTS
//  clk_i     in   1  system clock; must be >= 4x SCK frequency
//  rst_i     in   1  asynchronous reset, active high
//  sck_i     in   1  QSPI serial clock from master
//  cs_in     in   1  chip select, active low
//  sd_i      in   4  data lines, master -> model
//  sd_o      out  4  data lines, model -> master
//  sd_oen_o  out  4  per-line output enable, 1 = model drives
//  qpi_o     out  1  1 = QPI mode active (debug/visibility)
// BEHAVIOUR
//  Reset: state IDLE, qpi_o=0, sd_o=0, sd_oen_o=0, counters 0. Memory is NOT cleared.
//  Reset mid-frame aborts the frame; a partially shifted byte is discarded.
//  Edges: detected on synchronised sck (prev vs cur). Inputs are sampled on rising edges.
//   sd_o updates one clk_i after the falling edge is detected.
//  CS high (synchronised) in any state -> IDLE next clk, sd_oen_o=0, pending partial byte dropped.
//  Widths: cmd 8b; addr 24b, reduced mod DEPTH; 1 bit/edge on io0 (SPI) or 4 bits/edge (QPI/quad phases), MSB first.
//  FSM: IDLE -> CMD on CS fall.
//   CMD -> ADDR | IGNORE after 8 bits.
//   ADDR -> WR | RD | DUMMY after 24 bits.
//   DUMMY -> RD after DUMMY rising edges.
//   RD/WR stay until CS high.
//   IGNORE holds until CS high.
//  Commands (SPI mode; cmd on io0):
//   0x02 write: addr and data on io0.
//   0x03 read: addr on io0, no dummy, data on io1, sd_oen_o=4'b0010.
//   0x38 quad write: addr and data quad.
//   0xEB quad read: addr quad, DUMMY cycles, data quad, sd_oen_o=4'hF.
//   0x35 enter QPI: sets qpi_o at end of cmd.
//  QPI mode (cmd quad, 2 edges): 0x38 and 0xEB as above. 0xF5 exits QPI; qpi_o=0 at end of cmd. 0x02/0x03 -> IGNORE.
//  Unknown opcode -> IGNORE: no drive, no memory effect.
//  Write: byte committed to mem[addr] when its last bit/nibble is sampled; addr++ with wrap DEPTH-1 -> 0.
//  Read: first data bit/nibble driven on the falling edge after the last addr/dummy rising edge.
//   Next byte prefetched when the current byte's last bit/nibble is driven; addr++ with wrap.
//  Read-after-write in the same address: the new value is returned.
//  Simultaneous CS rise and SCK edge in one clk: CS wins and the edge is ignored.
// STRUCTURE
//  Package qspi_model_pkg:
//   opcode localparams (CMD_WR=0x02, CMD_RD=0x03, CMD_QWR=0x38, CMD_QRD=0xEB, CMD_EQPI=0x35, CMD_XQPI=0xF5).
//   typedef enum state_t {IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE}.
//  Sub-module qspi_sync_edge (SYNC-stage synchroniser + rise/fall pulses).
//   Instantiated for sck_i and cs_in; sd_i uses the synchroniser only.
//  Top holds the FSM, bit counter, address register, shift regs and the mem array.
// TESTING
//  1. SPI 0x02 @0x000010, data A5 3C; then 0x03 @0x000010 -> io1 returns A5 3C, oen=4'b0010.
//  2. 0x38 @0xFFFFFF (DEPTH=2^24), 11 22 -> mem[FFFFFF]=11, mem[000000]=22.
//     Then 0xEB @FFFFFF -> first nibble driven on falling edge after DUMMY=6 edges, reads 11 22.
//  3. 0x35, then QPI 0xEB @0x000010 -> A5; QPI 0x03 -> no drive.
//     0xF5 -> qpi_o=0; SPI 0x03 works again.
//  4. CS high after 4 bits of a 0x38 data byte at 0x20 (prev 0x77) -> mem[0x20] stays 77, oen=0 next clk.
//  5. rst_i pulse mid 0xEB read -> oen=0 and qpi_o=0 immediately; mem intact (re-read returns old data).
//  6. Opcode 0x9F -> oen stays 0 for the whole frame, no memory change.
//     The next frame after CS high decodes normally.

Source files
------------

// File: rtl/qspi_model_pkg.sv
// Shared opcodes, FSM state encoding and small helpers for the sampled QSPI PSRAM model.
package qspi_model_pkg;

    localparam logic [7:0] CMD_WR   = 8'h02;
    localparam logic [7:0] CMD_RD   = 8'h03;
    localparam logic [7:0] CMD_QWR  = 8'h38;
    localparam logic [7:0] CMD_QRD  = 8'hEB;
    localparam logic [7:0] CMD_EQPI = 8'h35;
    localparam logic [7:0] CMD_XQPI = 8'hF5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD,
        WR,
        IGNORE
    } state_t;

    // Single-line reads answer on io1; quad reads own all four lines.
    function automatic logic [3:0] rd_oen(input logic quad);
        return quad ? 4'hF : 4'b0010;
    endfunction

endpackage

// File: rtl/qspi_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses derived from the synchronised
// level (current sample vs. previous sample).
module qspi_sync_edge #(
    parameter int SYNC  = 2,
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] prev_q;

    if (SYNC == 0) begin : g_bypass
        assign q_o = d_i;
    end else begin : g_sync
        logic [WIDTH-1:0] stage_q [SYNC];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int i = 0; i < SYNC; i++) stage_q[i] <= '0;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < SYNC; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[SYNC-1];
    end

    // Resetting everything low means a CS already low at reset release never
    // produces a falling pulse, so an interrupted frame cannot restart mid-way.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= q_o;
    end

    assign rise_o = q_o & ~prev_q;
    assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/qspi_psram_sampled.sv
// QSPI/QPI PSRAM behavioural model sampled on the system clock: decodes SPI and
// QPI frames from oversampled SCK/CS and serves a byte-wide memory array.
module qspi_psram_sampled
    import qspi_model_pkg::*;
#(
    parameter int    DEPTH     = 16777216,
    parameter int    DUMMY     = 6,
    parameter int    SYNC      = 2,
    parameter string INIT_FILE = ""
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sck_i,
    input  logic       cs_in,
    input  logic [3:0] sd_i,
    output logic [3:0] sd_o,
    output logic [3:0] sd_oen_o,
    output logic       qpi_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = 8;

    logic       sck_s, sck_rise, sck_fall;
    logic       cs_s, cs_rise, cs_fall;
    logic [3:0] sd_s, sd_rise, sd_fall;

    qspi_sync_edge #(.SYNC(SYNC), .WIDTH(1)) u_sck_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sck_i),
        .q_o   (sck_s),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    qspi_sync_edge #(.SYNC(SYNC), .WIDTH(1)) u_cs_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cs_in),
        .q_o   (cs_s),
        .rise_o(cs_rise),
        .fall_o(cs_fall)
    );

    qspi_sync_edge #(.SYNC(SYNC), .WIDTH(4)) u_sd_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sd_i),
        .q_o   (sd_s),
        .rise_o(sd_rise),
        .fall_o(sd_fall)
    );

    logic unused_edges;
    assign unused_edges = ^{sck_s, cs_rise, sd_rise, sd_fall};

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [7:0]    cmd_q;
    logic [7:0]    op_q;
    logic [7:0]    shift_q;
    logic [23:0]   asr_q;
    logic [AW-1:0] addr_q;
    logic          quad_q;
    logic          qpi_q;
    logic [3:0]    sd_q;
    logic [3:0]    oen_q;
    logic [7:0]    mem_q [DEPTH];

    function automatic logic [AW-1:0] addr_mod(input logic [23:0] a);
        return AW'(32'(a) % 32'(DEPTH));
    endfunction

    function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
        return (32'(a) == 32'(DEPTH - 1)) ? '0 : a + AW'(1);
    endfunction

    logic [7:0]    cmd_d;
    logic [23:0]   asr_d;
    logic [7:0]    wr_d;
    logic [AW-1:0] addr_nx;
    logic          cmd_last;
    logic          addr_last;
    logic          byte_last;
    logic          dummy_last;
    logic          wr_en;

    // Shift-in values for the current edge; the command width follows QPI
    // mode, address/data width follows the opcode's quad flag.
    always_comb begin
        cmd_d      = qpi_q  ? {cmd_q[3:0], sd_s}   : {cmd_q[6:0], sd_s[0]};
        asr_d      = quad_q ? {asr_q[19:0], sd_s}  : {asr_q[22:0], sd_s[0]};
        wr_d       = quad_q ? {shift_q[3:0], sd_s} : {shift_q[6:0], sd_s[0]};
        cmd_last   = qpi_q  ? (cnt_q == CW'(1)) : (cnt_q == CW'(7));
        addr_last  = quad_q ? (cnt_q == CW'(5)) : (cnt_q == CW'(23));
        byte_last  = quad_q ? (cnt_q == CW'(1)) : (cnt_q == CW'(7));
        dummy_last = (cnt_q == CW'(DUMMY - 1));
        addr_nx    = addr_inc(addr_q);
        wr_en      = (state_q == WR) && sck_rise && !cs_s && byte_last;
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[addr_q] <= wr_d;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cmd_q   <= '0;
            op_q    <= '0;
            shift_q <= '0;
            asr_q   <= '0;
            addr_q  <= '0;
            quad_q  <= 1'b0;
            qpi_q   <= 1'b0;
            sd_q    <= '0;
            oen_q   <= '0;
        end else if (cs_s) begin
            // Deselect beats any SCK edge seen in the same clock.
            state_q <= IDLE;
            cnt_q   <= '0;
            sd_q    <= '0;
            oen_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q <= CMD;
                        cnt_q   <= '0;
                    end
                end
                CMD: begin
                    if (sck_rise) begin
                        cmd_q <= cmd_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cmd_last) begin
                            cnt_q   <= '0;
                            op_q    <= cmd_d;
                            state_q <= IGNORE;
                            case (cmd_d)
                                CMD_WR, CMD_RD: begin
                                    if (!qpi_q) begin
                                        state_q <= ADDR;
                                        quad_q  <= 1'b0;
                                    end
                                end
                                CMD_QWR, CMD_QRD: begin
                                    state_q <= ADDR;
                                    quad_q  <= 1'b1;
                                end
                                CMD_EQPI: if (!qpi_q) qpi_q <= 1'b1;
                                CMD_XQPI: if (qpi_q)  qpi_q <= 1'b0;
                                default: ;
                            endcase
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        asr_q <= asr_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (addr_last) begin
                            cnt_q  <= '0;
                            addr_q <= addr_mod(asr_d);
                            case (op_q)
                                CMD_WR, CMD_QWR: state_q <= WR;
                                CMD_RD: begin
                                    state_q <= RD;
                                    shift_q <= mem_q[addr_mod(asr_d)];
                                end
                                CMD_QRD: begin
                                    if (DUMMY == 0) begin
                                        state_q <= RD;
                                        shift_q <= mem_q[addr_mod(asr_d)];
                                    end else begin
                                        state_q <= qspi_model_pkg::DUMMY;
                                    end
                                end
                                default: state_q <= IGNORE;
                            endcase
                        end
                    end
                end
                qspi_model_pkg::DUMMY: begin
                    if (sck_rise) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (dummy_last) begin
                            cnt_q   <= '0;
                            state_q <= RD;
                            shift_q <= mem_q[addr_q];
                        end
                    end
                end
                RD: begin
                    // The byte after the current one is fetched as soon as the
                    // current byte's last bits go out on the bus.
                    if (sck_fall) begin
                        oen_q <= rd_oen(quad_q);
                        sd_q  <= quad_q ? shift_q[7:4] : {2'b00, shift_q[7], 1'b0};
                        cnt_q <= cnt_q + CW'(1);
                        if (byte_last) begin
                            cnt_q   <= '0;
                            addr_q  <= addr_nx;
                            shift_q <= mem_q[addr_nx];
                        end else begin
                            shift_q <= quad_q ? {shift_q[3:0], 4'h0} : {shift_q[6:0], 1'b0};
                        end
                    end
                end
                WR: begin
                    if (sck_rise) begin
                        cnt_q <= cnt_q + CW'(1);
                        if (byte_last) begin
                            cnt_q  <= '0;
                            addr_q <= addr_nx;
                        end else begin
                            shift_q <= wr_d;
                        end
                    end
                end
                IGNORE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sd_o     = sd_q;
    assign sd_oen_o = oen_q;
    assign qpi_o    = qpi_q;

endmodule

// File: tb/tb_qspi_psram_sampled.sv
// Directed bench for qspi_psram_sampled: a bit-banged QSPI master drives SPI and
// QPI frames and compares returned data/enables against hand-computed values.
module tb_qspi_psram_sampled;

    localparam int HALF = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic [3:0] sd_in = 4'h0;
    logic [3:0] sd_out;
    logic [3:0] oen;
    logic       qpi;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] oen_acc = 4'h0;

    qspi_psram_sampled dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .sck_i   (sck),
        .cs_in   (cs_n),
        .sd_i    (sd_in),
        .sd_o    (sd_out),
        .sd_oen_o(oen),
        .qpi_o   (qpi)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One SCK period: data set while low, model output sampled just before the rise.
    task automatic sck_cycle(input logic [3:0] din, output logic [3:0] dout);
        sd_in = din;
        repeat (HALF) @(negedge clk);
        dout    = sd_out;
        oen_acc = oen_acc | oen;
        sck     = 1'b1;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic cs_lo();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_hi();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cmd_spi(input logic [7:0] op);
        logic [3:0] d;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, op[i]}, d);
    endtask

    task automatic cmd_qpi(input logic [7:0] op);
        logic [3:0] d;
        sck_cycle(op[7:4], d);
        sck_cycle(op[3:0], d);
    endtask

    task automatic addr_spi(input logic [23:0] a);
        logic [3:0] d;
        for (int i = 23; i >= 0; i--) sck_cycle({3'b000, a[i]}, d);
    endtask

    task automatic addr_quad(input logic [23:0] a);
        logic [3:0] d;
        for (int i = 5; i >= 0; i--) sck_cycle(a[i*4 +: 4], d);
    endtask

    task automatic wr_spi(input logic [7:0] b);
        logic [3:0] d;
        for (int i = 7; i >= 0; i--) sck_cycle({3'b000, b[i]}, d);
    endtask

    task automatic wr_quad(input logic [7:0] b);
        logic [3:0] d;
        sck_cycle(b[7:4], d);
        sck_cycle(b[3:0], d);
    endtask

    task automatic dummy_cycles(input int n);
        logic [3:0] d;
        for (int i = 0; i < n; i++) sck_cycle(4'h0, d);
    endtask

    task automatic rd_spi(output logic [7:0] b);
        logic [3:0] d;
        for (int i = 7; i >= 0; i--) begin
            sck_cycle(4'h0, d);
            b[i] = d[1];
        end
    endtask

    task automatic rd_quad(output logic [7:0] b);
        logic [3:0] d;
        sck_cycle(4'h0, d);
        b[7:4] = d;
        sck_cycle(4'h0, d);
        b[3:0] = d;
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] d;

        repeat (3) @(negedge clk);
        check("rst_sd_o", 32'(sd_out), 32'h0);
        check("rst_oen", 32'(oen), 32'h0);
        check("rst_qpi", 32'(qpi), 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // SPI write A5 3C @0x10, then SPI read back on io1
        cs_lo(); cmd_spi(8'h02); addr_spi(24'h000010); wr_spi(8'hA5); wr_spi(8'h3C); cs_hi();
        cs_lo(); cmd_spi(8'h03); addr_spi(24'h000010);
        rd_spi(b); check("spi_rd_b0", 32'(b), 32'hA5);
        rd_spi(b); check("spi_rd_b1", 32'(b), 32'h3C);
        check("spi_rd_oen", 32'(oen), 32'h2);
        cs_hi();
        check("cs_hi_oen", 32'(oen), 32'h0);

        // Quad write across the top address, then quad read with dummy cycles
        cs_lo(); cmd_spi(8'h38); addr_quad(24'hFFFFFF); wr_quad(8'h11); wr_quad(8'h22); cs_hi();
        cs_lo(); cmd_spi(8'hEB); addr_quad(24'hFFFFFF); dummy_cycles(6);
        check("qrd_oen_before_data", 32'(oen), 32'h0);
        rd_quad(b); check("qrd_wrap_b0", 32'(b), 32'h11);
        rd_quad(b); check("qrd_wrap_b1", 32'(b), 32'h22);
        check("qrd_oen", 32'(oen), 32'hF);
        cs_hi();

        // Enter QPI, quad read, QPI 0x03 ignored, exit QPI, SPI read works
        cs_lo(); cmd_spi(8'h35); check("eqpi_qpi", 32'(qpi), 32'h1); cs_hi();
        cs_lo(); cmd_qpi(8'hEB); addr_quad(24'h000010); dummy_cycles(6);
        rd_quad(b); check("qpi_qrd_b0", 32'(b), 32'hA5);
        check("qpi_qrd_oen", 32'(oen), 32'hF);
        cs_hi();
        cs_lo(); oen_acc = 4'h0; cmd_qpi(8'h03); addr_quad(24'h000010);
        for (int i = 0; i < 4; i++) sck_cycle(4'h0, d);
        check("qpi_03_no_drive", 32'(oen_acc), 32'h0);
        cs_hi();
        cs_lo(); cmd_qpi(8'hF5); check("xqpi_qpi", 32'(qpi), 32'h0); cs_hi();
        cs_lo(); cmd_spi(8'h03); addr_spi(24'h000010);
        rd_spi(b); check("spi_after_xqpi", 32'(b), 32'hA5);
        cs_hi();

        // Reset in the middle of a QPI quad read
        cs_lo(); cmd_spi(8'h35); cs_hi();
        cs_lo(); cmd_qpi(8'hEB); addr_quad(24'h000010); dummy_cycles(6);
        rd_quad(b); check("pre_rst_b0", 32'(b), 32'hA5);
        check("pre_rst_oen", 32'(oen), 32'hF);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_oen", 32'(oen), 32'h0);
        check("mid_rst_qpi", 32'(qpi), 32'h0);
        check("mid_rst_sd_o", 32'(sd_out), 32'h0);
        repeat (3) @(negedge clk);
        cs_n = 1'b1;
        rst  = 1'b0;
        repeat (HALF) @(negedge clk);
        cs_lo(); cmd_spi(8'h03); addr_spi(24'h000010);
        rd_spi(b); check("post_rst_b0", 32'(b), 32'hA5);
        rd_spi(b); check("post_rst_b1", 32'(b), 32'h3C);
        cs_hi();

        // CS abort halfway through a quad write byte leaves memory untouched
        cs_lo(); cmd_spi(8'h38); addr_quad(24'h000020); wr_quad(8'h77); wr_quad(8'h66); cs_hi();
        cs_lo(); cmd_spi(8'h38); addr_quad(24'h000020); sck_cycle(4'h5, d); cs_hi();
        check("abort_oen", 32'(oen), 32'h0);
        cs_lo(); cmd_spi(8'h03); addr_spi(24'h000020);
        rd_spi(b); check("abort_keep_b0", 32'(b), 32'h77);
        rd_spi(b); check("abort_keep_b1", 32'(b), 32'h66);
        cs_hi();

        // Unknown opcode: no drive, no write; next frame decodes normally
        cs_lo(); oen_acc = 4'h0; cmd_spi(8'h9F); addr_spi(24'h000010);
        wr_spi(8'h00); wr_spi(8'hFF);
        check("unknown_no_drive", 32'(oen_acc), 32'h0);
        cs_hi();
        cs_lo(); cmd_spi(8'h03); addr_spi(24'h000010);
        rd_spi(b); check("unknown_keep_b0", 32'(b), 32'hA5);
        rd_spi(b); check("unknown_keep_b1", 32'(b), 32'h3C);
        cs_hi();
        check("final_qpi", 32'(qpi), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
